// File: rtl/text_sink_if.sv
// Character-stream handshake between the link decoder and text_sink.
//   in_data   character from the sender
//   in_valid  in_data is valid this cycle
//   in_ready  receiver can accept; a transfer occurs when in_valid && in_ready
// Modports: master = sender side, slave = text_sink side.
interface text_sink_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/text_sink.sv
// Receive end of the text link. Stores the incoming character stream in an internal RAM
// until the end-of-text marker, an idle timeout, or a buffer overflow, and reports the
// byte count, an 8-bit additive checksum and status flags. A registered read port exposes
// the buffer contents.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   in_if       character handshake (slave side: in_data, in_valid in; in_ready out)
//   clear       synchronous re-arm pulse; wins over a same-cycle character
//   rd_addr     buffer read address
//   rd_data     buffer word at rd_addr, registered (1-cycle latency, read-before-write)
//   byte_count  number of characters stored
//   checksum    sum mod 256 of stored characters
//   done        message complete (EOT, timeout or overflow)
//   timed_out   message ended by idle timeout
//   overflow    a non-EOT character arrived with the buffer full
module text_sink #(
    parameter int unsigned      DATA_W   = 8,
    parameter int unsigned      ADDR_W   = 10,
    parameter logic [DATA_W-1:0] EOT_CHAR = 8'h04,
    parameter logic [15:0]      TIMEOUT  = 16'd0
) (
    input  logic              clk,
    input  logic              reset,
    text_sink_if.slave        in_if,
    input  logic              clear,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum,
    output logic              done,
    output logic              timed_out,
    output logic              overflow
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRecv, StDone, StOvf} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        sum_q, sum_d;
    logic [15:0]       idle_q, idle_d;
    logic              to_q, to_d;
    logic              ovf_q, ovf_d;
    logic              mem_we;
    logic              xfer;
    logic              is_eot;
    logic [DATA_W-1:0] mem [DEPTH];

    assign in_if.in_ready = (state_q == StIdle) || (state_q == StRecv);
    assign xfer           = in_if.in_valid && in_if.in_ready;
    assign is_eot         = (in_if.in_data == EOT_CHAR);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        idle_d  = idle_q;
        to_d    = to_q;
        ovf_d   = ovf_q;
        mem_we  = 1'b0;
        if (clear) begin
            state_d = StIdle;
            count_d = '0;
            sum_d   = '0;
            idle_d  = '0;
            to_d    = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        if (is_eot) begin
                            state_d = StDone;
                        end else begin
                            // count_q is 0 in IDLE, so the write lands at address 0
                            mem_we  = 1'b1;
                            count_d = (ADDR_W + 1)'(1);
                            sum_d   = 8'(in_if.in_data);
                            idle_d  = '0;
                            state_d = StRecv;
                        end
                    end
                end
                StRecv: begin
                    if (xfer) begin
                        if (is_eot) begin
                            state_d = StDone;
                        end else if (count_q == FULL_COUNT) begin
                            ovf_d   = 1'b1;
                            state_d = StOvf;
                        end else begin
                            mem_we  = 1'b1;
                            count_d = count_q + 1'b1;
                            sum_d   = sum_q + 8'(in_if.in_data);
                            idle_d  = '0;
                        end
                    end else begin
                        // Saturate so a disabled timeout never wraps
                        if (idle_q != '1) begin
                            idle_d = idle_q + 1'b1;
                        end
                        if ((TIMEOUT != '0) && (idle_d == TIMEOUT)) begin
                            to_d    = 1'b1;
                            state_d = StDone;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            sum_q   <= '0;
            idle_q  <= '0;
            to_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            idle_q  <= idle_d;
            to_q    <= to_d;
            ovf_q   <= ovf_d;
        end
    end

    // RAM is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[count_q[ADDR_W-1:0]] <= in_if.in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    assign byte_count = count_q;
    assign checksum   = sum_q;
    assign done       = (state_q == StDone) || (state_q == StOvf);
    assign timed_out  = to_q;
    assign overflow   = ovf_q;
endmodule
